// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: UART (8N1) command receiver driving single 32-bit APB4
// transfers as a bus master, with a status/read-data response sent back on tx_o.
module uart_apb_bridge #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic [2:0]  pprot_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_WR = 8'hA5;
    localparam logic [7:0] CMD_RD = 8'h5A;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_SETUP  = 3'd3;
    localparam logic [2:0] S_ACCESS = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [2:0] S_TXWAIT = 3'd6;

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_vld_q, rx_vld_d;

    // Bit timing: the start bit is re-checked at half a bit, then every bit is
    // sampled one full bit later, which lands on the bit centres.
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                    else                  rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                // A low stop bit is a framing error: the byte is simply not flagged.
                if (rx_cnt_q == BIT_LAST) begin
                    rx_st_d  = RX_IDLE;
                    rx_vld_d = rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Receiver state, synchroniser and edge-detect history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_vld_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_vld_q   <= rx_vld_d;
        end
    end

    // ---------------- transmitter ----------------
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_done;

    // Last cycle of the stop bit; a new start issued here keeps bytes back-to-back.
    assign tx_done = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

    // Serialiser: start bit is driven on the same edge the byte is loaded.
    always_comb begin
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_start) begin
            tx_d       = 1'b0;
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, tx_byte};
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // Transmitter state; tx line idles high out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // ---------------- command FSM ----------------
    logic [2:0]    st_q, st_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [1:0]    resp_cnt_q, resp_cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Frame parsing, APB handshake and response sequencing.
    always_comb begin
        st_d       = st_q;
        byte_cnt_d = byte_cnt_q;
        resp_cnt_d = resp_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        to_cnt_d   = to_cnt_q;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        case (st_q)
            S_IDLE: begin
                if (rx_vld_q && (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD)) begin
                    st_d       = S_ADDR;
                    write_d    = (rx_shift_q == CMD_WR);
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_vld_q) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (st_q == S_ADDR) addr_d  = {rx_shift_q, addr_q[31:8]};
                    else                wdata_d = {rx_shift_q, wdata_q[31:8]};
                    if (byte_cnt_q == 2'd3)
                        st_d = (st_q == S_ADDR && write_q) ? S_DATA : S_SETUP;
                end else if (to_cnt_q == TO_LAST) begin
                    st_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_SETUP: st_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_i) begin
                    rdata_d    = prdata_i;
                    tx_start   = 1'b1;
                    tx_byte    = pslverr_i ? 8'hEE : 8'h00;
                    resp_cnt_d = '0;
                    st_d       = write_q ? S_TXWAIT : S_RESP;
                end
            end
            S_RESP: begin
                // Read data follows the status byte, LSB first.
                if (tx_done) begin
                    tx_start   = 1'b1;
                    tx_byte    = rdata_q[{resp_cnt_q, 3'b000} +: 8];
                    resp_cnt_d = resp_cnt_q + 1'b1;
                    if (resp_cnt_q == 2'd3) st_d = S_TXWAIT;
                end
            end
            S_TXWAIT: begin
                if (tx_done) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Command FSM registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q       <= S_IDLE;
            byte_cnt_q <= '0;
            resp_cnt_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            st_q       <= st_d;
            byte_cnt_q <= byte_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = (st_q != S_IDLE);
    assign psel_o    = (st_q == S_SETUP) || (st_q == S_ACCESS);
    assign penable_o = (st_q == S_ACCESS);
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pstrb_o   = write_q ? 4'hF : 4'h0;
    assign pprot_o   = 3'b000;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench for uart_apb_bridge: UART frames in, APB slave model, UART response decoder.
module tb_uart_apb_bridge;
    localparam int C  = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        tx, busy, psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    always #5 clk = ~clk;

    uart_apb_bridge #(.CLKS_PER_BIT(C), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx), .busy_o(busy),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [7:0]  status;
    } vec_t;

    apb_t       exp_apb[$];
    logic [7:0] exp_tx[$];
    int         cur_waits = 0;
    logic [31:0] cur_rdata = '0;
    logic       cur_err = 1'b0;
    int         apb_cnt = 0;
    bit         busy_seen = 1'b0;

    // APB slave model and bus checker.
    initial begin
        int acc = 0;
        int setup_n = 0;
        bit resp_pend = 1'b0;
        apb_t e;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (resp_pend) begin
                chk("resp_lat", {31'b0, tx}, 32'd0);
                resp_pend = 1'b0;
            end
            pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_0BAD;
            if (psel && !penable) begin
                setup_n++;
                acc = 0;
            end else if (psel && penable) begin
                if (acc == 0) chk("setup_len", setup_n, 32'd1);
                if (acc >= cur_waits) begin
                    pready = 1'b1; prdata = cur_rdata; pslverr = cur_err;
                    apb_cnt++;
                    resp_pend = 1'b1;
                    if (exp_apb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL apb_unexp: got addr %h, expected no transfer", paddr);
                    end else begin
                        e = exp_apb.pop_front();
                        chk("paddr", paddr, e.addr);
                        chk("pwrite", {31'b0, pwrite}, {31'b0, e.wr});
                        chk("pstrb", {28'b0, pstrb}, {28'b0, e.strb});
                        chk("pprot", {29'b0, pprot}, 32'd0);
                        if (e.wr) chk("pwdata", pwdata, e.wdata);
                    end
                end
                acc++;
            end else begin
                setup_n = 0;
                acc = 0;
            end
        end
    end

    // UART response decoder; every byte is checked against the scoreboard.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (C / 2) @(negedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                chk("tx_stop", {31'b0, tx}, 32'd1);
                if (exp_tx.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_unexp: got byte %h, expected none", b);
                end else begin
                    chk("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
                end
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_frame(input vec_t v);
        send_byte(v.wr ? 8'hA5 : 8'h5A);
        for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
        if (v.wr) for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
    endtask

    task automatic run_vec(input vec_t v);
        apb_t a;
        int n;
        cur_waits = v.waits; cur_rdata = v.rdata; cur_err = v.err;
        a.wr = v.wr; a.addr = v.addr; a.wdata = v.wdata; a.strb = v.wr ? 4'hF : 4'h0;
        exp_apb.push_back(a);
        exp_tx.push_back(v.status);
        if (!v.wr) for (int i = 0; i < 4; i++) exp_tx.push_back(v.rdata[8*i +: 8]);
        send_frame(v);
        chk("busy_hi", {31'b0, busy}, 32'd1);
        wait_idle(2000, n);
        chk("busy_drop", {31'b0, busy}, 32'd0);
        chk("apb_left", exp_apb.size(), 32'd0);
        chk("tx_left", exp_tx.size(), 32'd0);
        repeat (2 * C) @(negedge clk);
    endtask

    vec_t vecs[5];

    initial begin
        int n, a;
        vec_t v;
        vecs[0] = '{wr: 1'b1, addr: 32'h1000_0000, wdata: 32'hDEAD_BEEF, rdata: 32'h0,
                    waits: 0, err: 1'b0, status: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 32'h2000_0004, wdata: 32'h0, rdata: 32'h1234_5678,
                    waits: 3, err: 1'b0, status: 8'h00};
        vecs[2] = '{wr: 1'b1, addr: 32'h0000_0003, wdata: 32'h0000_0000, rdata: 32'h0,
                    waits: 1, err: 1'b1, status: 8'hEE};
        vecs[3] = '{wr: 1'b0, addr: 32'h4000_0010, wdata: 32'h0, rdata: 32'hA5A5_5A5A,
                    waits: 0, err: 1'b1, status: 8'hEE};
        vecs[4] = '{wr: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0123_4567, rdata: 32'h0,
                    waits: 2, err: 1'b0, status: 8'h00};

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", {28'b0, pstrb}, 32'd0);
        chk("rst_pprot", {29'b0, pprot}, 32'd0);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // unknown command byte and a framing error: ignored entirely
        busy_seen = 1'b0;
        a = apb_cnt;
        send_byte(8'h33);
        repeat (2 * C) @(negedge clk);
        send_byte(8'hA5, 1'b0);
        repeat (3 * C) @(negedge clk);
        chk("garbage_busy", {31'b0, busy_seen}, 32'd0);
        chk("garbage_apb", apb_cnt, a);
        run_vec(vecs[1]);

        // inter-byte timeout: partial frame abandoned silently
        a = apb_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        chk("to_busy_hi", {31'b0, busy}, 32'd1);
        wait_idle(400, n);
        chk("to_busy_drop", {31'b0, busy}, 32'd0);
        chk("to_window", {31'b0, (n >= 90 && n <= 115)}, 32'd1);
        repeat (4 * C) @(negedge clk);
        chk("to_apb", apb_cnt, a);
        chk("to_tx_left", exp_tx.size(), 32'd0);
        run_vec(vecs[0]);

        // reset while the slave is stalling in ACCESS
        cur_waits = 1_000_000; cur_err = 1'b0; cur_rdata = 32'h0;
        v = '{wr: 1'b0, addr: 32'h3000_0008, wdata: 32'h0, rdata: 32'h0,
              waits: 0, err: 1'b0, status: 8'h00};
        send_frame(v);
        n = 0;
        while (!penable && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", {31'b0, penable}, 32'd1);
        repeat (3) @(negedge clk);
        chk("stall_hold", {31'b0, penable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("arst_psel", {31'b0, psel}, 32'd0);
        chk("arst_penable", {31'b0, penable}, 32'd0);
        chk("arst_tx", {31'b0, tx}, 32'd1);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        repeat (2 * C) @(negedge clk);
        chk("arst_idle", {31'b0, busy}, 32'd0);
        run_vec(vecs[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
